lc3b_fetch_unit: RTL and testbench

Instruction-fetch stage of the LC-3b pipeline, and the producer side of the IF/ID pipeline register. It holds the PC and issues instruction-memory reads. It pre-decodes each fetched word into an `lc3b_ipacket` and presents one registered packet per cycle to IF/ID. It obeys the same `stall` that freezes IF/ID, and it discards wrong-path work when a taken branch redirects the PC.

---
 rtl/lc3b_fetch_unit_pkg.sv | 34 +++
 rtl/lc3b_fetch_unit_if.sv | 26 ++
 rtl/lc3b_predecode.sv | 23 ++
 rtl/lc3b_fetch_unit.sv | 139 +++++++++++++
 tb/tb_lc3b_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_fetch_unit_pkg.sv
// Shared LC-3b types for the fetch stage: word, IF/ID packet and fetch FSM states.
// Latency: n/a (types only).
// Backpressure: n/a. The all-zero packet is the pipeline bubble.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  // IF/ID packet. Every field not set by pre-decode stays 0.
  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
    logic     valid;
    lc3b_reg  dr_sr;
    lc3b_reg  sr1;
    lc3b_reg  sr2;
    logic     sr2_mux_sel;
  } lc3b_ipacket;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HELD  = 2'd2,
    FS_FLUSH = 2'd3
  } lc3b_fetch_state;

  localparam lc3b_ipacket IPACKET_BUBBLE = '0;

  // Sequential fetch address. It wraps modulo 2^16.
  function automatic lc3b_word pc_next(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/lc3b_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
// Latency: set by memory; imem_resp is a one-cycle completion.
// Backpressure: imem_read stays high with a stable address until imem_resp.
interface lc3b_fetch_unit_if;
  import lc3b_types::*;

  logic     imem_read;
  lc3b_word imem_address;
  lc3b_word imem_rdata;
  logic     imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );

endinterface

// File: rtl/lc3b_predecode.sv
// Pre-decode of a fetched word into an IF/ID packet (pc, ir, register fields).
// Latency: combinational.
// Backpressure: none. Ports: ir_i/pc_i in, pkt_o out.
module lc3b_predecode
  import lc3b_types::*;
(
  input  lc3b_word    ir_i,
  input  lc3b_word    pc_i,
  output lc3b_ipacket pkt_o
);

  always_comb begin
    pkt_o             = IPACKET_BUBBLE;
    pkt_o.pc          = pc_i;
    pkt_o.ir          = ir_i;
    pkt_o.valid       = 1'b1;
    pkt_o.dr_sr       = ir_i[11:9];
    pkt_o.sr1         = ir_i[8:6];
    pkt_o.sr2         = ir_i[2:0];
    pkt_o.sr2_mux_sel = ir_i[5];
  end

endmodule

// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction fetch. Holds the PC, reads imem and drives a registered IF/ID packet.
// Latency: a word returned at edge N is on ipacket_out after edge N; one instr/cycle with zero-wait memory.
// Backpressure: stall freezes the packet. A word that arrives while stalled parks in a holding register.
// Ports: clk, reset_n (async active-low), stall, redirect/redirect_pc,
//        imem (master modport of lc3b_fetch_unit_if), ipacket_out.
module lc3b_fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
)
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  lc3b_word                 redirect_pc,
  lc3b_fetch_unit_if.master        imem,
  output lc3b_ipacket              ipacket_out
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        req_addr_q, req_addr_d;
  lc3b_word        held_ir_q, held_ir_d;
  lc3b_word        held_pc_q, held_pc_d;
  lc3b_ipacket     ipkt_q, ipkt_d;

  lc3b_word        redirect_tgt;
  logic            slot_free;
  lc3b_word        pd_ir;
  lc3b_word        pd_pc;
  lc3b_ipacket     pd_pkt;

  // One pre-decoder serves both the live response and the HELD reload.
  assign pd_ir = (state_q == FS_HELD) ? held_ir_q : imem.imem_rdata;
  assign pd_pc = (state_q == FS_HELD) ? held_pc_q : pc_q;

  lc3b_predecode u_predecode (
    .ir_i  (pd_ir),
    .pc_i  (pd_pc),
    .pkt_o (pd_pkt)
  );

  assign redirect_tgt = redirect_pc & 16'hFFFE;
  // A new packet can be written if the current one is a bubble or leaves this edge.
  assign slot_free    = ~ipkt_q.valid | ~stall;

  // FLUSH keeps presenting the orphaned address until its response drains.
  assign imem.imem_read    = (state_q == FS_FETCH) || (state_q == FS_FLUSH);
  assign imem.imem_address = (state_q == FS_FLUSH) ? req_addr_q : pc_q;
  assign ipacket_out       = ipkt_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    held_ir_d  = held_ir_q;
    held_pc_d  = held_pc_q;
    ipkt_d     = ipkt_q;

    case (state_q)
      FS_IDLE: begin
        state_d = FS_FETCH;
        if (redirect) begin
          ipkt_d = IPACKET_BUBBLE;
          pc_d   = redirect_tgt;
        end
      end

      FS_FETCH: begin
        if (redirect) begin
          ipkt_d = IPACKET_BUBBLE;
          pc_d   = redirect_tgt;
          if (!imem.imem_resp) begin
            // The request to the old pc is still open. Keep its address
            // stable until memory answers.
            req_addr_d = pc_q;
            state_d    = FS_FLUSH;
          end
        end else if (imem.imem_resp) begin
          pc_d = pc_next(pc_q);
          if (slot_free) begin
            ipkt_d = pd_pkt;
          end else begin
            held_ir_d = imem.imem_rdata;
            held_pc_d = pc_q;
            state_d   = FS_HELD;
          end
        end else if (!stall) begin
          ipkt_d = IPACKET_BUBBLE;
        end
      end

      FS_HELD: begin
        if (redirect) begin
          ipkt_d  = IPACKET_BUBBLE;
          pc_d    = redirect_tgt;
          state_d = FS_FETCH;
        end else if (!stall) begin
          ipkt_d  = pd_pkt;
          state_d = FS_FETCH;
        end
      end

      FS_FLUSH: begin
        if (redirect) begin
          ipkt_d = IPACKET_BUBBLE;
          pc_d   = redirect_tgt;
        end
        if (imem.imem_resp) begin
          state_d = FS_FETCH;
        end
      end

      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      held_ir_q  <= '0;
      held_pc_q  <= '0;
      ipkt_q     <= IPACKET_BUBBLE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      held_ir_q  <= held_ir_d;
      held_pc_q  <= held_pc_d;
      ipkt_q     <= ipkt_d;
    end
  end

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Self-checking bench for lc3b_fetch_unit: directed scenarios plus randomized stall/redirect/latency.
// Latency: n/a.
// Backpressure: the memory model answers after 0..2 (or a fixed number of) wait cycles.
module tb_lc3b_fetch_unit;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall;
  logic        redirect;
  lc3b_word    redirect_pc;
  lc3b_ipacket ipacket_out;

  lc3b_fetch_unit_if imem_if ();

  lc3b_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_if),
    .ipacket_out (ipacket_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lc3b_word word_at(input lc3b_word a);
    if (a == 16'h0000) return 16'h1283;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Behavioural model: fetch progress expressed as a few flags plus the expected packet.
  bit       m_started;
  lc3b_word m_pc;
  bit       m_flush;
  lc3b_word m_flush_addr;
  bit       m_held;
  lc3b_word m_held_pc, m_held_ir;
  bit       m_pvalid;
  lc3b_word m_ppc, m_pir;

  task automatic model_reset();
    m_started = 0; m_pc = 16'h0000; m_flush = 0; m_flush_addr = 16'h0000;
    m_held = 0; m_held_pc = 0; m_held_ir = 0; m_pvalid = 0; m_ppc = 0; m_pir = 0;
  endtask

  task automatic model_step();
    bit       resp;
    lc3b_word data, tgt, old;
    resp = imem_if.imem_resp;
    data = imem_if.imem_rdata;
    tgt  = redirect_pc & 16'hFFFE;
    if (!m_started) begin
      m_started = 1;
      if (redirect) begin m_pvalid = 0; m_pc = tgt; end
    end else if (redirect) begin
      m_pvalid = 0; old = m_pc; m_pc = tgt;
      if (m_held) m_held = 0;
      else if (m_flush) begin if (resp) m_flush = 0; end
      else if (!resp) begin m_flush = 1; m_flush_addr = old; end
    end else if (m_held) begin
      if (!stall) begin m_pvalid = 1; m_ppc = m_held_pc; m_pir = m_held_ir; m_held = 0; end
    end else if (m_flush) begin
      if (resp) m_flush = 0;
    end else if (resp) begin
      if (!m_pvalid || !stall) begin m_pvalid = 1; m_ppc = m_pc; m_pir = data; end
      else begin m_held = 1; m_held_pc = m_pc; m_held_ir = data; end
      m_pc = m_pc + 16'd2;
    end else if (!stall) begin
      m_pvalid = 0;
    end
  endtask

  function automatic lc3b_ipacket expect_pkt();
    lc3b_ipacket p;
    p = '0;
    if (m_pvalid) begin
      p.pc = m_ppc; p.ir = m_pir; p.valid = 1'b1;
      p.dr_sr = m_pir[11:9]; p.sr1 = m_pir[8:6]; p.sr2 = m_pir[2:0]; p.sr2_mux_sel = m_pir[5];
    end
    return p;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Compare process, on the inactive clock edge.
  always @(negedge clk) begin
    logic exp_read;
    exp_read = m_started && !m_held;
    chk("imem_read", {63'd0, imem_if.imem_read}, {63'd0, exp_read});
    if (exp_read || !m_started)
      chk("imem_address", {48'd0, imem_if.imem_address}, {48'd0, (m_flush ? m_flush_addr : m_pc)});
    chk("ipacket", {21'd0, ipacket_out}, {21'd0, expect_pkt()});
  end

  // Memory model.
  bit in_req;
  int lat;
  int mem_lat;
  bit late_resp;

  task automatic drive_mem();
    imem_if.imem_resp  = 1'b0;
    imem_if.imem_rdata = lc3b_word'($urandom);
    if (late_resp) begin
      imem_if.imem_resp  = 1'b1;
      imem_if.imem_rdata = 16'hDEAD;
      late_resp = 0;
    end else if (reset_n && imem_if.imem_read) begin
      if (!in_req) begin
        in_req = 1;
        lat = (mem_lat < 0) ? $urandom_range(0, 2) : mem_lat;
      end
      if (lat == 0) begin
        imem_if.imem_resp  = 1'b1;
        imem_if.imem_rdata = word_at(imem_if.imem_address);
        in_req = 0;
      end else begin
        lat--;
      end
    end
  endtask

  task automatic cycle(input logic st, input logic rd, input lc3b_word rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    drive_mem();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    in_req = 0; late_resp = 0;
    stall = 0; redirect = 0; imem_if.imem_resp = 1'b0;
    #1;
    chk("rst_read", {63'd0, imem_if.imem_read}, 64'd0);
    chk("rst_addr", {48'd0, imem_if.imem_address}, 64'h0000);
    chk("rst_valid", {63'd0, ipacket_out.valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    lc3b_word r;
    model_reset();
    stall = 0; redirect = 0; redirect_pc = 0;
    imem_if.imem_resp = 1'b0; imem_if.imem_rdata = 16'h0000;
    mem_lat = 0; in_req = 0; late_resp = 0; lat = 0;
    #1;
    apply_reset();

    // First fetch, zero-wait memory.
    chk("idle_read", {63'd0, imem_if.imem_read}, 64'd0);
    cycle(0, 0, 0);
    chk("first_read", {63'd0, imem_if.imem_read}, 64'd1);
    chk("first_addr", {48'd0, imem_if.imem_address}, 64'h0000);
    cycle(0, 0, 0);
    chk("pkt0_pc", {48'd0, ipacket_out.pc}, 64'h0000);
    chk("pkt0_dr", {61'd0, ipacket_out.dr_sr}, 64'd1);
    chk("pkt0_sr1", {61'd0, ipacket_out.sr1}, 64'd2);
    chk("pkt0_sr2", {61'd0, ipacket_out.sr2}, 64'd3);
    chk("pkt0_mux", {63'd0, ipacket_out.sr2_mux_sel}, 64'd0);
    chk("pkt0_valid", {63'd0, ipacket_out.valid}, 64'd1);
    chk("next_addr", {48'd0, imem_if.imem_address}, 64'h0002);

    // Stall for 3 cycles while the word at 0x0002 arrives.
    cycle(1, 0, 0);
    chk("held_read", {63'd0, imem_if.imem_read}, 64'd0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("held_read2", {63'd0, imem_if.imem_read}, 64'd0);
    chk("held_pkt_pc", {48'd0, ipacket_out.pc}, 64'h0000);
    cycle(0, 0, 0);
    chk("reload_pc", {48'd0, ipacket_out.pc}, 64'h0002);
    chk("reload_ir", {48'd0, ipacket_out.ir}, {48'd0, word_at(16'h0002)});
    chk("reload_addr", {48'd0, imem_if.imem_address}, 64'h0004);
    cycle(0, 0, 0);
    chk("after_reload_pc", {48'd0, ipacket_out.pc}, 64'h0004);

    // Redirect while waiting on 0x0010.
    for (int n = 0; n < 40 && imem_if.imem_address != 16'h0010; n++) cycle(0, 0, 0);
    chk("reach_0010", {48'd0, imem_if.imem_address}, 64'h0010);
    mem_lat = 3;
    cycle(0, 0, 0);
    cycle(0, 1, 16'h3000);
    chk("flush_addr", {48'd0, imem_if.imem_address}, 64'h0010);
    chk("flush_read", {63'd0, imem_if.imem_read}, 64'd1);
    chk("flush_bubble", {21'd0, ipacket_out}, 64'd0);
    cycle(0, 0, 0);
    chk("flush_addr2", {48'd0, imem_if.imem_address}, 64'h0010);
    mem_lat = 0;
    cycle(0, 0, 0);
    chk("target_addr", {48'd0, imem_if.imem_address}, 64'h3000);
    chk("orphan_dropped", {63'd0, ipacket_out.valid}, 64'd0);
    cycle(0, 0, 0);
    chk("target_pc", {48'd0, ipacket_out.pc}, 64'h3000);
    chk("target_ir", {48'd0, ipacket_out.ir}, {48'd0, word_at(16'h3000)});

    // Redirect together with a response while stalled.
    cycle(1, 1, 16'h4000);
    chk("rr_bubble", {63'd0, ipacket_out.valid}, 64'd0);
    chk("rr_addr", {48'd0, imem_if.imem_address}, 64'h4000);
    chk("rr_read", {63'd0, imem_if.imem_read}, 64'd1);

    // PC wrap and odd redirect target.
    cycle(0, 1, 16'hFFFE);
    chk("wrap_addr0", {48'd0, imem_if.imem_address}, 64'hFFFE);
    cycle(0, 0, 0);
    chk("wrap_pkt_pc", {48'd0, ipacket_out.pc}, 64'hFFFE);
    chk("wrap_addr", {48'd0, imem_if.imem_address}, 64'h0000);
    cycle(0, 1, 16'h5001);
    chk("odd_tgt", {48'd0, imem_if.imem_address}, 64'h5000);

    // Reset in the middle of a request, then a late response.
    mem_lat = 3;
    cycle(0, 0, 0);
    #2;
    apply_reset();
    late_resp = 1;
    cycle(0, 0, 0);
    chk("late_read", {63'd0, imem_if.imem_read}, 64'd1);
    chk("late_addr", {48'd0, imem_if.imem_address}, 64'h0000);
    chk("late_ignored", {63'd0, ipacket_out.valid}, 64'd0);
    mem_lat = 0;
    cycle(0, 0, 0);
    chk("restart_pc", {48'd0, ipacket_out.pc}, 64'h0000);
    chk("restart_ir", {48'd0, ipacket_out.ir}, 64'h1283);

    // Randomized traffic.
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        apply_reset();
      end
      r = lc3b_word'($urandom);
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
